// File: rtl/cell_core_issue_if.sv
// ---------------------------------------------------------------------------
// cell_core_issue_if
// Instruction handshake channel into the cell core issue stage.
//   instr_valid  producer -> stage   instruction word present
//   instr        producer -> stage   16-bit instruction word
//   instr_ready  stage -> producer   stage can accept this cycle
// master: the instruction producer; slave: the issue stage.
// ---------------------------------------------------------------------------
interface cell_core_issue_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;

   modport master (
      output instr_valid,
      output instr,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr,
      output instr_ready
   );
endinterface

// File: rtl/cell_core_issue.sv
// ---------------------------------------------------------------------------
// cell_core_issue
// Issue and writeback stage of a cell core. Accepts 16-bit instructions,
// reads the register file (with forwarding of the in-flight result), drives
// the external cell ALU from execute registers and writes the ALU result back
// on the following edge. Also owns the host configuration write port, the
// retire counter and a sticky illegal-opcode flag.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   instr_if (slave)      instr_valid / instr / instr_ready handshake
//   alu_opcode            execute opcode to the ALU
//   alu_immediate         raw 8-bit immediate (ALU sign-extends)
//   alu_first_operand     rs1 value
//   alu_second_operand    rs2 value
//   alu_result            combinational ALU result for the execute slot
//   cfg_we/addr/wdata     host register write (blocks instruction accept)
//   cell_state            registered copy of r[STATE_REG]
//   retire                one-cycle pulse per retired instruction
//   retired_count         16-bit wrapping retire counter
//   illegal_op            sticky flag: undefined opcode retired
// Opcode map: LI=0 ADD=1 SUB=2 AND=3 OR=4 NOR=5 SEQ=6 SLT=7 MUL=8 SHR=9
// FMUL=A; B..F are undefined.
// ---------------------------------------------------------------------------
module cell_core_issue #(
   parameter int REGISTER_LENGTH = 32,
   parameter int NUM_REGISTERS   = 16,
   parameter int STATE_REG       = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   cell_core_issue_if.slave           instr_if,
   output logic [3:0]                 alu_opcode,
   output logic [7:0]                 alu_immediate,
   output logic [REGISTER_LENGTH-1:0] alu_first_operand,
   output logic [REGISTER_LENGTH-1:0] alu_second_operand,
   input  logic [REGISTER_LENGTH-1:0] alu_result,
   input  logic                       cfg_we,
   input  logic [3:0]                 cfg_addr,
   input  logic [REGISTER_LENGTH-1:0] cfg_wdata,
   output logic [REGISTER_LENGTH-1:0] cell_state,
   output logic                       retire,
   output logic [15:0]                retired_count,
   output logic                       illegal_op
);

   localparam logic [3:0] STATE_ADDR = 4'(STATE_REG);

   // True for every opcode the ALU implements.
   function automatic logic op_defined(input logic [3:0] op);
      logic def;
      case (op)
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
         4'h6, 4'h7, 4'h8, 4'h9, 4'hA: def = 1'b1;
         default:                      def = 1'b0;
      endcase
      return def;
   endfunction

   // Register file and execute-stage registers
   logic [REGISTER_LENGTH-1:0] rf_q [NUM_REGISTERS];
   logic                       e_valid_q;
   logic [3:0]                 e_opcode_q;
   logic [3:0]                 e_rd_q;
   logic [7:0]                 e_imm_q;
   logic [REGISTER_LENGTH-1:0] e_a_q;
   logic [REGISTER_LENGTH-1:0] e_b_q;
   logic [REGISTER_LENGTH-1:0] cell_state_q;
   logic [REGISTER_LENGTH-1:0] cell_state_d;
   logic                       retire_q;
   logic [15:0]                retired_count_q;
   logic                       illegal_q;

   // Combinational decode / control
   logic                       accept_s;
   logic                       wb_en_s;
   logic                       host_en_s;
   logic [3:0]                 rs1_s;
   logic [3:0]                 rs2_s;
   logic [REGISTER_LENGTH-1:0] rs1_val_s;
   logic [REGISTER_LENGTH-1:0] rs2_val_s;

   assign instr_if.instr_ready = !cfg_we;
   assign accept_s = instr_if.instr_valid && !cfg_we;
   assign rs1_s    = instr_if.instr[7:4];
   assign rs2_s    = instr_if.instr[3:0];

   // A writing execute slot is both the writeback enable and the forward source.
   assign wb_en_s   = e_valid_q && op_defined(e_opcode_q) && (e_rd_q != 4'd0);
   // Writeback takes priority over a host write to the same register.
   assign host_en_s = cfg_we && (cfg_addr != 4'd0) && !(wb_en_s && (e_rd_q == cfg_addr));

   // Operand read: r0 is zero, in-flight result is forwarded, else register file.
   always_comb begin
      rs1_val_s = '0;
      rs2_val_s = '0;
      if (rs1_s == 4'd0) begin
         rs1_val_s = '0;
      end else if (wb_en_s && (e_rd_q == rs1_s)) begin
         rs1_val_s = alu_result;
      end else begin
         rs1_val_s = rf_q[rs1_s];
      end
      if (rs2_s == 4'd0) begin
         rs2_val_s = '0;
      end else if (wb_en_s && (e_rd_q == rs2_s)) begin
         rs2_val_s = alu_result;
      end else begin
         rs2_val_s = rf_q[rs2_s];
      end
   end

   // Next cell state: tracks whatever lands in r[STATE_REG] this edge.
   always_comb begin
      cell_state_d = cell_state_q;
      if (wb_en_s && (e_rd_q == STATE_ADDR)) begin
         cell_state_d = alu_result;
      end else if (host_en_s && (cfg_addr == STATE_ADDR)) begin
         cell_state_d = cfg_wdata;
      end else begin
         cell_state_d = cell_state_q;
      end
   end

   // Execute registers: load on accept; operands/opcode hold while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_valid_q  <= 1'b0;
         e_opcode_q <= 4'd0;
         e_rd_q     <= 4'd0;
         e_imm_q    <= 8'd0;
         e_a_q      <= '0;
         e_b_q      <= '0;
      end else begin
         e_valid_q <= accept_s;
         if (accept_s) begin
            e_opcode_q <= instr_if.instr[15:12];
            e_rd_q     <= instr_if.instr[11:8];
            e_imm_q    <= instr_if.instr[7:0];
            e_a_q      <= rs1_val_s;
            e_b_q      <= rs2_val_s;
         end else begin
            e_opcode_q <= e_opcode_q;
            e_rd_q     <= e_rd_q;
            e_imm_q    <= e_imm_q;
            e_a_q      <= e_a_q;
            e_b_q      <= e_b_q;
         end
      end
   end

   // Register file writes (host and writeback) plus the cell state mirror.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGISTERS; i++) begin
            rf_q[i] <= '0;
         end
         cell_state_q <= '0;
      end else begin
         if (host_en_s) begin
            rf_q[cfg_addr] <= cfg_wdata;
         end
         if (wb_en_s) begin
            rf_q[e_rd_q] <= alu_result;
         end
         cell_state_q <= cell_state_d;
      end
   end

   // Retire pulse, retire counter and sticky illegal-opcode flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_q        <= 1'b0;
         retired_count_q <= 16'd0;
         illegal_q       <= 1'b0;
      end else begin
         retire_q <= e_valid_q;
         if (e_valid_q) begin
            retired_count_q <= retired_count_q + 16'd1;
         end else begin
            retired_count_q <= retired_count_q;
         end
         if (e_valid_q && !op_defined(e_opcode_q)) begin
            illegal_q <= 1'b1;
         end else begin
            illegal_q <= illegal_q;
         end
      end
   end

   assign alu_opcode         = e_opcode_q;
   assign alu_immediate      = e_imm_q;
   assign alu_first_operand  = e_a_q;
   assign alu_second_operand = e_b_q;
   assign cell_state         = cell_state_q;
   assign retire             = retire_q;
   assign retired_count      = retired_count_q;
   assign illegal_op         = illegal_q;

endmodule

// File: tb/tb_cell_core_issue.sv
// ---------------------------------------------------------------------------
// tb_cell_core_issue
// Directed bench for cell_core_issue. A behavioural cell ALU closes the loop
// from the alu_* outputs to alu_result. Register contents are observed by
// issuing "OR r0,rs,r0" probes and reading alu_first_operand.
// ---------------------------------------------------------------------------
module tb_cell_core_issue;

   localparam logic [3:0] OP_LI   = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_NOR  = 4'h5;
   localparam logic [3:0] OP_SEQ  = 4'h6;
   localparam logic [3:0] OP_SLT  = 4'h7;
   localparam logic [3:0] OP_MUL  = 4'h8;
   localparam logic [3:0] OP_SHR  = 4'h9;
   localparam logic [3:0] OP_FMUL = 4'hA;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  alu_opcode;
   logic [7:0]  alu_immediate;
   logic [31:0] alu_first_operand;
   logic [31:0] alu_second_operand;
   logic [31:0] alu_result;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cell_state;
   logic        retire;
   logic [15:0] retired_count;
   logic        illegal_op;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] exp_count;

   always #5 clk = ~clk;

   cell_core_issue_if ifc ();

   cell_core_issue #(
      .REGISTER_LENGTH (32),
      .NUM_REGISTERS   (16),
      .STATE_REG       (1)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .instr_if           (ifc),
      .alu_opcode         (alu_opcode),
      .alu_immediate      (alu_immediate),
      .alu_first_operand  (alu_first_operand),
      .alu_second_operand (alu_second_operand),
      .alu_result         (alu_result),
      .cfg_we             (cfg_we),
      .cfg_addr           (cfg_addr),
      .cfg_wdata          (cfg_wdata),
      .cell_state         (cell_state),
      .retire             (retire),
      .retired_count      (retired_count),
      .illegal_op         (illegal_op)
   );

   // Behavioural cell ALU.
   logic signed [63:0] fa, fb, fprod;
   always_comb begin
      fa         = {{32{alu_first_operand[31]}}, alu_first_operand};
      fb         = {{32{alu_second_operand[31]}}, alu_second_operand};
      fprod      = fa * fb;
      alu_result = 32'd0;
      case (alu_opcode)
         OP_LI:   alu_result = {{24{alu_immediate[7]}}, alu_immediate};
         OP_ADD:  alu_result = alu_first_operand + alu_second_operand;
         OP_SUB:  alu_result = alu_first_operand - alu_second_operand;
         OP_AND:  alu_result = alu_first_operand & alu_second_operand;
         OP_OR:   alu_result = alu_first_operand | alu_second_operand;
         OP_NOR:  alu_result = ~(alu_first_operand | alu_second_operand);
         OP_SEQ:  alu_result = (alu_first_operand == alu_second_operand) ? 32'd1 : 32'd0;
         OP_SLT:  alu_result = ($signed(alu_first_operand) < $signed(alu_second_operand)) ? 32'd1 : 32'd0;
         OP_MUL:  alu_result = alu_first_operand * alu_second_operand;
         OP_SHR:  alu_result = alu_first_operand >> alu_second_operand[4:0];
         OP_FMUL: alu_result = fprod[47:16];
         default: alu_result = 32'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
      return {op, rd, rs1, rs2};
   endfunction

   function automatic logic [15:0] li(input logic [3:0] rd, input logic [7:0] imm);
      return {OP_LI, rd, imm};
   endfunction

   task automatic issue(input logic [15:0] i);
      ifc.instr_valid = 1'b1;
      ifc.instr       = i;
      @(posedge clk); #1;
      ifc.instr_valid = 1'b0;
      exp_count       = exp_count + 16'd1;
   endtask

   task automatic idle(input int n);
      ifc.instr_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic probe(input string tag, input logic [3:0] rs, input logic [31:0] exp);
      issue(mk(OP_OR, 4'd0, rs, 4'd0));
      check(tag, alu_first_operand, exp);
   endtask

   task automatic host_write(input logic [3:0] a, input logic [31:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(posedge clk); #1;
      cfg_we    = 1'b0;
   endtask

   initial begin
      int n;
      rst             = 1'b1;
      cfg_we          = 1'b0;
      cfg_addr        = 4'd0;
      cfg_wdata       = 32'd0;
      ifc.instr_valid = 1'b0;
      ifc.instr       = 16'd0;
      exp_count       = 16'd0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check("rst_retire", {31'd0, retire}, 32'd0);
      check("rst_count", {16'd0, retired_count}, 32'd0);
      check("rst_illegal", {31'd0, illegal_op}, 32'd0);
      check("rst_cell_state", cell_state, 32'd0);
      check("rst_ready", {31'd0, ifc.instr_ready}, 32'd1);

      // Reset mid-stream with LI r2,5 in flight
      rst = 1'b0;
      issue(li(4'd2, 8'd5));
      check("inflight_imm", {24'd0, alu_immediate}, 32'd5);
      rst = 1'b1;
      #1;
      check("async_clear_imm", {24'd0, alu_immediate}, 32'd0);
      check("async_clear_op", {28'd0, alu_opcode}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_count = 16'd0;
      @(posedge clk); #1;
      check("rst_no_retire", {31'd0, retire}, 32'd0);
      check("rst_no_count", {16'd0, retired_count}, 32'd0);
      check("rst_opnd_a", alu_first_operand, 32'd0);
      check("rst_opnd_b", alu_second_operand, 32'd0);
      probe("rst_r2", 4'd2, 32'd0);

      // Forwarding: LI r1,7; ADD r2,r1,r1; ADD r3,r2,r1
      issue(li(4'd1, 8'd7));
      issue(mk(OP_ADD, 4'd2, 4'd1, 4'd1));
      check("fwd_a_r1", alu_first_operand, 32'd7);
      check("fwd_add_r2", alu_result, 32'd14);
      issue(mk(OP_ADD, 4'd3, 4'd2, 4'd1));
      check("fwd_a_r2", alu_first_operand, 32'd14);
      check("rf_b_r1", alu_second_operand, 32'd7);
      check("fwd_add_r3", alu_result, 32'd21);
      idle(1);
      check("fwd_cell_state", cell_state, 32'd7);
      check("fwd_count", {16'd0, retired_count}, {16'd0, exp_count});
      probe("fwd_r2", 4'd2, 32'd14);
      probe("fwd_r3", 4'd3, 32'd21);

      // Sign extension and FMUL
      issue(li(4'd4, 8'hFF));
      probe("li_neg_r4", 4'd4, 32'hFFFF_FFFF);
      host_write(4'd5, 32'h0001_8000);
      host_write(4'd6, 32'h0002_0000);
      issue(mk(OP_FMUL, 4'd7, 4'd5, 4'd6));
      check("fmul_result", alu_result, 32'h0003_0000);
      probe("fmul_r7", 4'd7, 32'h0003_0000);

      // r0 is hardwired to zero
      idle(2);
      issue(li(4'd0, 8'd9));
      issue(mk(OP_ADD, 4'd8, 4'd0, 4'd0));
      check("r0_no_fwd", alu_first_operand, 32'd0);
      check("r0_retire1", {31'd0, retire}, 32'd1);
      idle(1);
      check("r0_retire2", {31'd0, retire}, 32'd1);
      idle(1);
      check("r0_retire_end", {31'd0, retire}, 32'd0);
      probe("r0_r8", 4'd8, 32'd0);

      // Host write blocks accept for the two cycles it is held
      idle(2);
      ifc.instr       = li(4'd9, 8'h33);
      ifc.instr_valid = 1'b1;
      cfg_we          = 1'b1;
      cfg_addr        = 4'd10;
      cfg_wdata       = 32'h0000_00AB;
      #1;
      check("host_ready_low", {31'd0, ifc.instr_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      cfg_we          = 1'b0;
      ifc.instr_valid = 1'b0;
      check("host_no_retire_a", {31'd0, retire}, 32'd0);
      idle(1);
      check("host_no_retire_b", {31'd0, retire}, 32'd0);
      check("host_count", {16'd0, retired_count}, {16'd0, exp_count});
      probe("host_r9_untouched", 4'd9, 32'd0);
      probe("host_r10", 4'd10, 32'h0000_00AB);

      // Same-edge conflict: writeback wins
      issue(li(4'd3, 8'd2));
      host_write(4'd3, 32'd1);
      probe("conflict_r3", 4'd3, 32'd2);
      // Different addresses on the same edge: both land
      issue(li(4'd11, 8'd4));
      host_write(4'd12, 32'h0000_0055);
      probe("both_r11", 4'd11, 32'd4);
      probe("both_r12", 4'd12, 32'h0000_0055);
      host_write(4'd1, 32'h0000_1234);
      check("host_cell_state", cell_state, 32'h0000_1234);

      // Illegal opcode
      idle(1);
      check("illegal_pre", {31'd0, illegal_op}, 32'd0);
      issue(mk(4'hF, 4'd2, 4'd0, 4'd0));
      check("illegal_not_yet", {31'd0, illegal_op}, 32'd0);
      idle(1);
      check("illegal_set", {31'd0, illegal_op}, 32'd1);
      check("illegal_retire", {31'd0, retire}, 32'd1);
      check("illegal_count", {16'd0, retired_count}, {16'd0, exp_count});
      probe("illegal_r2_kept", 4'd2, 32'd14);
      idle(3);
      check("illegal_sticky", {31'd0, illegal_op}, 32'd1);

      // Retire counter wrap 0xFFFF -> 0x0000
      n = 32'hFFFF - int'(exp_count);
      ifc.instr       = mk(OP_OR, 4'd0, 4'd0, 4'd0);
      ifc.instr_valid = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      ifc.instr_valid = 1'b0;
      exp_count = exp_count + 16'(n);
      idle(1);
      check("count_ffff", {16'd0, retired_count}, 32'h0000_FFFF);
      issue(mk(OP_OR, 4'd0, 4'd0, 4'd0));
      idle(1);
      check("count_wrap", {16'd0, retired_count}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cell_core_issue.md
# cell_core_issue

Issue and writeback stage of a cell core: accepts 16-bit instructions over a valid/ready handshake, decodes them, reads the cell's register file, and presents opcode, immediate and operands to the cell ALU. On the following clock edge it writes the ALU result back. It sits directly upstream and downstream of `cell_core_alu`: it drives that block's inputs and consumes its `result`. It owns the register file, the operand forwarding, an illegal-opcode flag, a retire counter and a host configuration port.

## Interface
- `REGISTER_LENGTH`, 32: register and ALU operand width (≥16; FMUL is Q16.16).
- `NUM_REGISTERS`, 16: register count; addresses are 4 bits. r0 reads as 0.
- `STATE_REG`, 1: index of the register exported as the cell state.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  stage can accept; equals `!cfg_we`.
- `instr`  in  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2; LI uses [7:0] as the immediate.
- `alu_opcode`  out  4  to the ALU.
- `alu_immediate`  out  8  to the ALU, raw; the ALU sign-extends it.
- `alu_first_operand`  out  REGISTER_LENGTH  rs1 value.
- `alu_second_operand`  out  REGISTER_LENGTH  rs2 value.
- `alu_result`  in  REGISTER_LENGTH  ALU output, combinational from the above.
- `cfg_we`  in  1  host register write.
- `cfg_addr`  in  4  host write address.
- `cfg_wdata`  in  REGISTER_LENGTH  host write data.
- `cell_state`  out  REGISTER_LENGTH  registered copy of r[STATE_REG].
- `retire`  out  1  one-cycle pulse per retired instruction.
- `retired_count`  out  16  retired instructions; wraps.
- `illegal_op`  out  1  sticky; set when an undefined opcode retires.

## Operation
- **Accept.** An instruction is accepted on a rising edge where `instr_valid && instr_ready`. At that edge the execute registers load:
  - `e_valid`=1 and `e_opcode`.
  - `e_rd`, and `e_imm`=instr[7:0].
  - `e_a`=read(rs1) and `e_b`=read(rs2).
  - With no accept at an edge, `e_valid` loads 0.
- **Read rule.** Address 0 returns 0. Otherwise, if `e_valid && e_writes && e_rd==addr`, return `alu_result` (forwarding). Otherwise return the register file content.
- **ALU drive.** `alu_*` outputs come directly from the `e_*` registers. They hold their values when `e_valid`=0.
- **Writeback.** At the edge ending a cycle with `e_valid`=1:
  - If the opcode is defined (LI, ADD, SUB, AND, OR, NOR, SEQ, SLT, MUL, SHR, FMUL per the ISA macros) and `e_rd`≠0, write r[e_rd] ← `alu_result`.
  - If the opcode is undefined, there is no write and `illegal_op` is set.
  - In all cases pulse `retire` and increment `retired_count` (mod 2^16).
- **Host write.** A host write is performed when `cfg_we` and `cfg_addr`≠0.
  - If it targets the same address as a writeback at the same edge, the writeback wins.
  - Different addresses are both written.
  - No instruction is accepted while `cfg_we`=1.
- **Cell state.** `cell_state` loads the value written to r[STATE_REG] at the same edge as that write. It therefore mirrors the register with no extra lag.
- **Reset.** Assertion clears all registers immediately, including any in-flight instruction, which is discarded without retiring. Reset values:
  - All registers, `e_*`, `cell_state`, `retired_count` = 0.
  - `retire`, `illegal_op` = 0.
  - `instr_ready` follows `!cfg_we`; there is no reset dependence.

## Timing
- Accept at edge N → ALU inputs valid in cycle N..N+1 → r[rd] written and `retire` high after edge N+1.
- Throughput is one instruction per cycle. There are no stalls other than `cfg_we`.
- Back-to-back dependent instructions need no bubbles: forwarding covers the 1-cycle hazard. The register file covers older results.
- The combinational path `alu_result` → operand mux → `e_a`/`e_b` is the critical path. It must close at the target clock.
- The `retire` pulse is registered and high for exactly the cycle after the writeback edge.

## Test plan
- **Reset:** reset mid-stream with LI r2,5 in flight → after reset r2=0, no `retire`, `retired_count`=0, all outputs 0.
- **Forwarding:** LI r1,7; ADD r2,r1,r1; ADD r3,r2,r1 back-to-back → r2=14, r3=21, `cell_state`=7, `retired_count`=3.
- **Sign and FMUL:** LI r4,-1 → r4=0xFFFFFFFF. Host writes r5=0x00018000 (1.5) and r6=0x00020000 (2.0); then FMUL r7,r5,r6 → r7=0x00030000.
- **r0:** LI r0,9 followed by ADD r8,r0,r0 → r8=0, `retire` pulses twice.
- **Host port:** `cfg_we` held for 2 cycles while `instr_valid`=1 → `instr_ready`=0 and nothing accepted. Same-edge conflict: host write r3=1 at the same edge as a writeback of 2 to r3 → r3=2.
- **Illegal opcode:** opcode 0xF retires → no register changes, `illegal_op`=1 and stays set, `retired_count` increments. Also check 0xFFFF→0x0000 wrap.
